// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared widths and FSM state type for stream_demux_1to4
package demux_pkg;

  localparam int DATA_W  = 8;
  localparam int NUM_OUT = 4;
  localparam int SEL_W   = 2;
  localparam int CNT_W   = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/stream_demux_1to4_if.sv
// rtl/stream_demux_1to4_if.sv - input stream and four packed output streams of the demux
interface stream_demux_1to4_if;
  import demux_pkg::*;

  logic [DATA_W-1:0]         in_data;
  logic [SEL_W-1:0]          in_sel;
  logic                      in_last;
  logic                      in_valid;
  logic                      in_ready;
  logic [NUM_OUT*DATA_W-1:0] out_data;
  logic [NUM_OUT-1:0]        out_last;
  logic [NUM_OUT-1:0]        out_valid;
  logic [NUM_OUT-1:0]        out_ready;

  modport master (
    output in_data, in_sel, in_last, in_valid, out_ready,
    input  in_ready, out_data, out_last, out_valid
  );

  modport slave (
    input  in_data, in_sel, in_last, in_valid, out_ready,
    output in_ready, out_data, out_last, out_valid
  );

endinterface

// File: rtl/demux_slot.sv
// rtl/demux_slot.sv - one-entry output register slot with valid/ready drain
module demux_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         wr_last,
  input  logic         rd_ready,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         last
);

  // A write wins over a same-edge drain, leaving the slot full with the new beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      last  <= 1'b0;
    end else if (wr_en) begin
      valid <= 1'b1;
      data  <= wr_data;
      last  <= wr_last;
    end else if (valid && rd_ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux_1to4.sv
// rtl/stream_demux_1to4.sv - packet-locked 1:4 stream demux; DEMUX_BEAT_CNT_EN adds per-channel beat counters
module stream_demux_1to4
  import demux_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  stream_demux_1to4_if.slave      bus,
  output logic                    busy
`ifdef DEMUX_BEAT_CNT_EN
  ,
  output logic [NUM_OUT*CNT_W-1:0] beat_cnt
`endif
);

  state_t             state;
  logic [SEL_W-1:0]   lock_sel;
  logic [SEL_W-1:0]   tgt;
  logic               accept;
  logic [NUM_OUT-1:0] wr_en;
  logic [NUM_OUT-1:0] slot_valid;
  logic [NUM_OUT-1:0] slot_last;
  logic [DATA_W-1:0]  slot_data [NUM_OUT];

  // in_sel only matters for the first beat; mid-packet the latched channel is used.
  assign tgt          = (state == LOCKED) ? lock_sel : bus.in_sel;
  assign bus.in_ready = !rst && (!slot_valid[tgt] || bus.out_ready[tgt]);
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    wr_en      = '0;
    wr_en[tgt] = accept;
  end

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
    demux_slot #(.W(DATA_W)) u_slot (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en[k]),
      .wr_data  (bus.in_data),
      .wr_last  (bus.in_last),
      .rd_ready (bus.out_ready[k]),
      .valid    (slot_valid[k]),
      .data     (slot_data[k]),
      .last     (slot_last[k])
    );
  end

  always_comb begin
    bus.out_data = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      bus.out_data[k*DATA_W +: DATA_W] = slot_data[k];
    end
  end

  assign bus.out_valid = slot_valid;
  assign bus.out_last  = slot_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      lock_sel <= '0;
      busy     <= 1'b0;
    end else if (accept) begin
      case (state)
        IDLE: begin
          if (!bus.in_last) begin
            state    <= LOCKED;
            lock_sel <= bus.in_sel;
            busy     <= 1'b1;
          end
        end
        LOCKED: begin
          if (bus.in_last) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef DEMUX_BEAT_CNT_EN
  logic [CNT_W-1:0] cnt [NUM_OUT];

  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_OUT; k++) begin
      if (rst) begin
        cnt[k] <= '0;
      end else if (slot_valid[k] && bus.out_ready[k] && (cnt[k] != {CNT_W{1'b1}})) begin
        cnt[k] <= cnt[k] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    beat_cnt = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      beat_cnt[k*CNT_W +: CNT_W] = cnt[k];
    end
  end
`endif

endmodule

// File: tb/tb_stream_demux_1to4.sv
// tb/tb_stream_demux_1to4.sv - directed scoreboard bench for stream_demux_1to4
module tb_stream_demux_1to4;
  import demux_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic busy;
`ifdef DEMUX_BEAT_CNT_EN
  logic [NUM_OUT*CNT_W-1:0] beat_cnt;
`endif

  stream_demux_1to4_if bus ();

  stream_demux_1to4 dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy)
`ifdef DEMUX_BEAT_CNT_EN
    ,
    .beat_cnt (beat_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [8:0] q [NUM_OUT][$];
  logic       m_locked;
  logic [1:0] m_lock;
  int         run3;
  int         max_run3;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: a beat leaves channel k at the next edge when valid&ready now.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      for (int k = 0; k < NUM_OUT; k++) begin
        if (bus.out_valid[k] === 1'b1 && bus.out_ready[k] === 1'b1) begin
          check($sformatf("ch%0d_beat_expected", k), 64'(q[k].size() != 0), 64'd1);
          if (q[k].size() != 0) begin
            logic [8:0] e;
            e = q[k].pop_front();
            check($sformatf("ch%0d_beat", k), {bus.out_last[k], bus.out_data[k*DATA_W +: DATA_W]}, e);
          end
        end
      end
      if (bus.out_valid[3] === 1'b1) run3++;
      else run3 = 0;
      if (run3 > max_run3) max_run3 = run3;
    end
  end

  task automatic send(input logic [1:0] sel, input logic [7:0] d, input logic last, output int waits);
    logic [1:0] t;
    waits = 0;
    bus.in_valid = 1'b1;
    bus.in_sel   = sel;
    bus.in_data  = d;
    bus.in_last  = last;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    check("in_ready_accept", 64'(bus.in_ready), 64'd1);
    t = m_locked ? m_lock : sel;
    q[t].push_back({last, d});
    if (!m_locked && !last) begin
      m_locked = 1'b1;
      m_lock   = sel;
    end else if (m_locked && last) begin
      m_locked = 1'b0;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic clear_model();
    for (int k = 0; k < NUM_OUT; k++) q[k].delete();
    m_locked = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_sel    = 2'd0;
    bus.in_data   = 8'h00;
    bus.in_last   = 1'b0;
    bus.out_ready = 4'hF;
    m_locked      = 1'b0;
    m_lock        = 2'd0;
    run3          = 0;
    max_run3      = 0;

    // Reset held with input offered
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_in_ready", 64'(bus.in_ready), 64'd0);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
`ifdef DEMUX_BEAT_CNT_EN
      check("rst_beat_cnt", 64'(beat_cnt), 64'd0);
`endif
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;

    // Single-beat packet to channel 2
    send(2'd2, 8'hA5, 1'b1, w);
    check("single_out_valid", 64'(bus.out_valid), 64'b0100);
    check("single_out_data", 64'(bus.out_data[23:16]), 64'hA5);
    check("single_busy", 64'(busy), 64'd0);

    // Packet lock: later in_sel values are ignored
    send(2'd1, 8'h10, 1'b0, w);
    check("lock_busy_after_first", 64'(busy), 64'd1);
    check("lock_first_on_ch1", 64'(bus.out_valid), 64'b0010);
    send(2'd3, 8'h11, 1'b0, w);
    send(2'bxx, 8'h12, 1'b1, w);
    check("lock_busy_after_last", 64'(busy), 64'd0);
    check("lock_last_on_ch1", 64'(bus.out_valid), 64'b0010);
    repeat (2) @(posedge clk);
    #1;

    // Backpressure isolation
    bus.out_ready = 4'b1110;
    send(2'd0, 8'h55, 1'b1, w);
    bus.in_valid = 1'b1;
    bus.in_sel   = 2'd0;
    bus.in_data  = 8'h66;
    bus.in_last  = 1'b1;
    @(negedge clk);
    check("bp_in_ready_blocked", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1;
    send(2'd2, 8'h20, 1'b0, w);
    check("bp_ch2_beat0_waits", 64'(w), 64'd0);
    send(2'd2, 8'h21, 1'b0, w);
    check("bp_ch2_beat1_waits", 64'(w), 64'd0);
    send(2'd2, 8'h22, 1'b1, w);
    check("bp_ch2_beat2_waits", 64'(w), 64'd0);
    check("bp_ch0_valid_held", 64'(bus.out_valid[0]), 64'd1);
    check("bp_ch0_data_held", 64'(bus.out_data[7:0]), 64'h55);
    bus.out_ready = 4'b1111;
    repeat (2) @(posedge clk);
    #1;

    // Throughput: 8 back-to-back beats to channel 3
    max_run3 = 0;
    for (int i = 0; i < 8; i++) begin
      send(2'd3, 8'(8'h80 + i), (i == 7), w);
    end
    repeat (3) @(posedge clk);
    #1;
    check("tput_ch3_run", 64'(max_run3), 64'd8);
`ifdef DEMUX_BEAT_CNT_EN
    check("tput_beat_cnt3", 64'(beat_cnt[63:48]), 64'd8);
`endif

    // Reset in the middle of a 5-beat packet
    send(2'd1, 8'h30, 1'b0, w);
    send(2'd1, 8'h31, 1'b0, w);
    check("mid_busy_before_rst", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_model();
    check("mid_out_valid", 64'(bus.out_valid), 64'd0);
    check("mid_busy", 64'(busy), 64'd0);
`ifdef DEMUX_BEAT_CNT_EN
    check("mid_beat_cnt", 64'(beat_cnt), 64'd0);
`endif
    send(2'd0, 8'h40, 1'b1, w);
    check("mid_next_out_valid", 64'(bus.out_valid), 64'b0001);
    check("mid_next_out_data", 64'(bus.out_data[7:0]), 64'h40);

    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NUM_OUT; k++) begin
      check($sformatf("ch%0d_drained", k), 64'(q[k].size()), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
